// File: rtl/mips_io_port.sv
// rtl/mips_io_port.sv - memory-mapped I/O words (PortOut, debounced PortIn, status) beside the data RAM
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-high reset
//   Address    load/store address (ALU result); bits [1:0] ignored by the decode
//   WriteData  store data
//   MemWrite   store strobe
//   MemRead    load strobe
//   PortIn     raw asynchronous input pins
//   IOSelect   address hits one of the three I/O words
//   IOReadData combinational load data for the selected I/O word (0 when not reading)
//   PortOut    registered output port
`timescale 1ns/1ps

module mips_io_port #(
    parameter logic [31:0] PORT_OUT_ADDR   = 32'h1001_0024,
    parameter logic [31:0] PORT_IN_ADDR    = 32'h1001_0028,
    parameter logic [31:0] STATUS_ADDR     = 32'h1001_002C,
    parameter int          PORT_IN_WIDTH   = 8,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Address,
    input  logic [31:0]              WriteData,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [PORT_IN_WIDTH-1:0] PortIn,
    output logic                     IOSelect,
    output logic [31:0]              IOReadData,
    output logic [31:0]              PortOut
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic                     hit_out;
    logic                     hit_in;
    logic                     hit_stat;
    logic                     unused_addr_bits;

    logic [PORT_IN_WIDTH-1:0] sync_q1;
    logic [PORT_IN_WIDTH-1:0] sync_q2;
    logic [PORT_IN_WIDTH-1:0] in_prev;
    logic [PORT_IN_WIDTH-1:0] debounced;
    logic [PORT_IN_WIDTH-1:0] debounced_next;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_next;
    logic                     chg_flag;

    // Word-granular decode: byte offsets within a word alias to the same register.
    assign hit_out  = (Address[31:2] == PORT_OUT_ADDR[31:2]);
    assign hit_in   = (Address[31:2] == PORT_IN_ADDR[31:2]);
    assign hit_stat = (Address[31:2] == STATUS_ADDR[31:2]);
    assign IOSelect = hit_out | hit_in | hit_stat;
    assign unused_addr_bits = ^Address[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PortOut <= '0;
        end else if (MemWrite && hit_out) begin
            PortOut <= WriteData;
        end
    end

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= PortIn;
            sync_q2 <= sync_q1;
        end
    end

    // A candidate differing from the accepted value must stay identical for
    // DEBOUNCE_CYCLES consecutive samples; any change of candidate restarts the
    // count at 1. The >= compare keeps DEBOUNCE_CYCLES=1 from wrapping forever.
    always_comb begin
        debounced_next = debounced;
        count_next     = count;
        if (sync_q2 == debounced) begin
            count_next = '0;
        end else if (sync_q2 != in_prev) begin
            count_next = CW'(1);
        end else if (count >= LAST_COUNT) begin
            debounced_next = sync_q2;
            count_next     = '0;
        end else begin
            count_next = count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_prev   <= '0;
            debounced <= '0;
            count     <= '0;
        end else begin
            in_prev   <= sync_q2;
            debounced <= debounced_next;
            count     <= count_next;
        end
    end

    // Sticky change flag; a new change on the same edge as a clearing read wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg_flag <= 1'b0;
        end else if (debounced_next != debounced) begin
            chg_flag <= 1'b1;
        end else if (MemRead && hit_in) begin
            chg_flag <= 1'b0;
        end
    end

    // Reads see pre-edge state, so a simultaneous store to PortOut returns the old value.
    always_comb begin
        IOReadData = '0;
        if (MemRead) begin
            if (hit_out) begin
                IOReadData = PortOut;
            end else if (hit_in) begin
                IOReadData = 32'(debounced);
            end else if (hit_stat) begin
                IOReadData = {30'b0, (sync_q2 != debounced), chg_flag};
            end
        end
    end

endmodule

// File: tb/tb_mips_io_port.sv
// tb/tb_mips_io_port.sv - directed self-checking bench for mips_io_port
`timescale 1ns/1ps

module tb_mips_io_port;

    localparam logic [31:0] A_OUT  = 32'h1001_0024;
    localparam logic [31:0] A_IN   = 32'h1001_0028;
    localparam logic [31:0] A_STAT = 32'h1001_002C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic        IOSelect;
    logic [31:0] IOReadData;
    logic [31:0] PortOut;

    int checks = 0;
    int errors = 0;

    mips_io_port dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .PortIn     (PortIn),
        .IOSelect   (IOSelect),
        .IOReadData (IOReadData),
        .PortOut    (PortOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] addr);
        Address = addr;
        MemRead = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd(A_STAT);
        check("rst_status", IOReadData, 32'h0);
        check("rst_portout", PortOut, 32'h0);
        check("stat_iosel", {31'b0, IOSelect}, 32'h1);

        // Store to PortOut, visible next cycle
        MemRead = 1'b0; MemWrite = 1'b1; Address = A_OUT; WriteData = 32'hDEAD_BEEF;
        #1;
        check("st_before_edge", PortOut, 32'h0);
        tick();
        check("st_after_edge", PortOut, 32'hDEAD_BEEF);
        MemWrite = 1'b0;
        rd(A_OUT);
        check("ld_portout", IOReadData, 32'hDEAD_BEEF);

        // Store to read-only PORT_IN word is ignored
        MemRead = 1'b0; MemWrite = 1'b1; Address = A_IN; WriteData = 32'h1234_5678;
        tick();
        MemWrite = 1'b0;
        check("ro_st_portout", PortOut, 32'hDEAD_BEEF);
        rd(A_IN);
        check("ro_st_portin", IOReadData, 32'h0);
        rd(A_STAT);
        check("ro_st_status", IOReadData, 32'h0);

        // Decode: byte offset alias, miss, hit without read
        rd(32'h1001_0026);
        check("alias_data", IOReadData, 32'hDEAD_BEEF);
        check("alias_iosel", {31'b0, IOSelect}, 32'h1);
        rd(32'h1001_0030);
        check("miss_iosel", {31'b0, IOSelect}, 32'h0);
        check("miss_data", IOReadData, 32'h0);
        Address = A_OUT; MemRead = 1'b0; #1;
        check("noread_data", IOReadData, 32'h0);
        check("noread_iosel", {31'b0, IOSelect}, 32'h1);

        // Simultaneous read and write of PortOut: read returns the old value
        MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'hCAFE_0001; #1;
        check("rw_old", IOReadData, 32'hDEAD_BEEF);
        tick();
        MemWrite = 1'b0; #1;
        check("rw_new", IOReadData, 32'hCAFE_0001);

        // PortIn 00->5A accepted on the 6th edge
        rd(A_STAT);
        PortIn = 8'h5A;
        for (int i = 0; i < 5; i++) tick();
        check("deb_pending_stat", IOReadData, 32'h2);
        rd(A_IN);
        check("deb_not_at_5", IOReadData, 32'h0);
        rd(A_STAT);
        tick();
        check("deb_stat_after", IOReadData, 32'h1);
        rd(A_IN);
        check("deb_at_6", IOReadData, 32'h5A);

        // Clear the flag with a PORT_IN read edge
        tick();
        rd(A_STAT);
        check("flag_cleared", IOReadData, 32'h0);

        // Clearing read on the accept edge: set wins
        PortIn = 8'h3C;
        for (int i = 0; i < 5; i++) tick();
        rd(A_IN);
        tick();
        check("setwins_data", IOReadData, 32'h3C);
        rd(A_STAT);
        check("setwins_flag", IOReadData, 32'h1);
        rd(A_IN);
        tick();
        rd(A_STAT);
        check("next_read_clears", IOReadData, 32'h0);

        // 3-cycle glitch is rejected
        PortIn = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        PortIn = 8'h3C;
        for (int i = 0; i < 6; i++) tick();
        rd(A_IN);
        check("glitch_data", IOReadData, 32'h3C);
        rd(A_STAT);
        check("glitch_flag", IOReadData, 32'h0);

        // 4-cycle pulse is accepted
        PortIn = 8'hFF;
        for (int i = 0; i < 4; i++) tick();
        PortIn = 8'h3C;
        tick();
        tick();
        rd(A_IN);
        check("pulse4_data", IOReadData, 32'hFF);
        rd(A_STAT);
        check("pulse4_stat", IOReadData, 32'h3);
        for (int i = 0; i < 4; i++) tick();
        rd(A_IN);
        check("pulse4_return", IOReadData, 32'h3C);

        // Asynchronous mid-cycle reset during a partial qualification
        PortIn = 8'hA5;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        rd(A_OUT);
        check("async_rst_portout", PortOut, 32'h0);
        check("async_rst_rdout", IOReadData, 32'h0);
        rd(A_STAT);
        check("async_rst_status", IOReadData, 32'h0);
        tick();
        reset = 1'b0;
        rd(A_STAT);
        check("post_rst_status", IOReadData, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        rd(A_IN);
        check("requal_not_at_5", IOReadData, 32'h0);
        rd(A_STAT);
        tick();
        rd(A_IN);
        check("requal_at_6", IOReadData, 32'hA5);
        MemRead = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
